// File: rtl/wishbone_bridge.sv
// -----------------------------------------------------------------------------
// wishbone_bridge
//
// Turns the CPU's single-cycle data bus (address, read/write strobes, write
// data) into one Wishbone B4 classic master cycle per access. The CPU is held
// with `stall` until the slave acknowledges, signals an error, or the access
// times out. Load data is returned through a register.
//
// Parameters
//    TIMEOUT_CYCLES  maximum BUS-state cycles before an access is aborted with
//                    an error; 0 disables the timeout.
//
// Ports
//    clock          system clock, rising edge
//    reset          asynchronous, active-high
//    address        CPU byte address (word accesses only)
//    read_enable    CPU load request, held until stall drops
//    write_enable   CPU store request, held until stall drops (wins over read)
//    write_data     CPU store data
//    read_data      registered load data, valid from the DONE cycle
//    stall          CPU must hold its state this cycle
//    bus_error      one-cycle pulse in DONE when the access failed
//    wb_cyc_o/stb_o Wishbone cycle and strobe (decoded from the state register)
//    wb_we_o        Wishbone write enable
//    wb_adr_o       Wishbone address
//    wb_dat_o       Wishbone write data
//    wb_sel_o       Wishbone byte select (all lanes during a cycle)
//    wb_dat_i       Wishbone read data
//    wb_ack_i       Wishbone acknowledge
//    wb_err_i       Wishbone error
// -----------------------------------------------------------------------------
module wishbone_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read_enable,
   input  logic        write_enable,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        stall,
   output logic        bus_error,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   // A disabled timeout still gets a 1-bit counter so no zero-width vector
   // is ever declared.
   localparam int unsigned CNT_W_RAW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CNT_W      = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
   localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS,
      ST_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic             req;
   logic             misaligned;
   logic             timeout_hit;

   logic [31:0]      adr_q;
   logic [31:0]      dat_q;
   logic             we_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   assign req         = read_enable | write_enable;
   assign misaligned  = |address[1:0];
   assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      bus_error = 1'b0;
      wb_cyc_o  = 1'b0;
      wb_stb_o  = 1'b0;
      wb_we_o   = 1'b0;
      wb_adr_o  = '0;
      wb_dat_o  = '0;
      wb_sel_o  = '0;

      case (state)
         ST_IDLE: begin
            if (req) begin
               state_nxt = misaligned ? ST_DONE : ST_BUS;
            end
         end
         ST_BUS: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_we_o  = we_q;
            wb_adr_o = adr_q;
            wb_dat_o = dat_q;
            wb_sel_o = 4'b1111;
            if (wb_err_i || wb_ack_i || timeout_hit) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            bus_error = err_q;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // The reset term keeps stall low while reset is held even though the
      // CPU strobes may still be high.
      stall = req && (state != ST_DONE) && !reset;
   end

   // ------------------------------------------------------------------
   // Request capture, timeout counter, error flag, read data
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         adr_q     <= '0;
         dat_q     <= '0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         read_data <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  if (misaligned) begin
                     err_q <= 1'b1;
                  end else begin
                     adr_q <= address;
                     dat_q <= write_data;
                     we_q  <= write_enable;
                     err_q <= 1'b0;
                     cnt_q <= '0;
                  end
               end
            end
            ST_BUS: begin
               // Priority: error, then acknowledge, then timeout.
               if (wb_err_i) begin
                  err_q <= 1'b1;
               end else if (wb_ack_i) begin
                  err_q <= 1'b0;
                  if (!we_q) begin
                     read_data <= wb_dat_i;
                  end
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DONE: begin
               err_q <= 1'b0;
            end
            default: begin
               err_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wishbone_bridge.sv
module tb_wishbone_bridge;

   logic        clock;
   logic        reset;
   logic [31:0] address;
   logic        read_enable;
   logic        write_enable;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        stall;
   logic        bus_error;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;

   wishbone_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .address      (address),
      .read_enable  (read_enable),
      .write_enable (write_enable),
      .write_data   (write_data),
      .read_data    (read_data),
      .stall        (stall),
      .bus_error    (bus_error),
      .wb_cyc_o     (wb_cyc_o),
      .wb_stb_o     (wb_stb_o),
      .wb_we_o      (wb_we_o),
      .wb_adr_o     (wb_adr_o),
      .wb_dat_o     (wb_dat_o),
      .wb_sel_o     (wb_sel_o),
      .wb_dat_i     (wb_dat_i),
      .wb_ack_i     (wb_ack_i),
      .wb_err_i     (wb_err_i)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Slave model: mode 0 acks, mode 1 raises err and ack together, mode 2
   // never answers. The response comes after `slave_wait` wait states.
   int          slave_mode;
   int          slave_wait;
   int          s_cnt;
   logic [31:0] slave_rdata;

   always @(posedge clock or posedge reset) begin
      if (reset || !wb_cyc_o) s_cnt <= 0;
      else                    s_cnt <= s_cnt + 1;
   end

   assign wb_ack_i = wb_cyc_o && (slave_mode != 2) && (s_cnt == slave_wait);
   assign wb_err_i = wb_cyc_o && (slave_mode == 1) && (s_cnt == slave_wait);
   assign wb_dat_i = slave_rdata;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        re;
      logic        we;
      int          mode;
      int          wt;
      logic [31:0] sdata;
      int          exp_stall;
      int          exp_bus;
      logic        exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t q[$];
   vec_t vecs[10];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Monitor: accumulates per-access observations, compares at DONE
   // ------------------------------------------------------------------
   initial begin : monitor
      int   m_stall;
      int   m_bus;
      logic m_bad;
      vec_t e;
      m_stall = 0;
      m_bus   = 0;
      m_bad   = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            m_stall = 0;
            m_bus   = 0;
            m_bad   = 1'b0;
         end else if (read_enable || write_enable) begin
            if (stall) begin
               m_stall++;
               if (bus_error) m_bad = 1'b1;
               if (wb_cyc_o) begin
                  m_bus++;
                  if (q.size() > 0) begin
                     if (wb_stb_o !== 1'b1 || wb_sel_o !== 4'hF ||
                         wb_we_o !== q[0].we || wb_adr_o !== q[0].addr ||
                         wb_dat_o !== q[0].wdata)
                        m_bad = 1'b1;
                  end
               end
            end else begin
               if (q.size() == 0) begin
                  check("unexpected_completion", 32'd1, 32'd0);
               end else begin
                  e = q.pop_front();
                  check("stall_cycles", m_stall, e.exp_stall);
                  check("bus_cycles",   m_bus,   e.exp_bus);
                  check("bus_error",    {31'd0, bus_error}, {31'd0, e.exp_err});
                  check("read_data",    read_data, e.exp_rd);
                  check("bus_signals",  {31'd0, m_bad}, 32'd0);
                  check("cyc_in_done",  {31'd0, wb_cyc_o}, 32'd0);
               end
               m_stall = 0;
               m_bus   = 0;
               m_bad   = 1'b0;
            end
         end else begin
            check("idle_quiet", {29'd0, stall, bus_error, wb_cyc_o}, 32'd0);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic run_vec(input vec_t v);
      int n;
      @(posedge clock);
      #1;
      slave_mode   = v.mode;
      slave_wait   = v.wt;
      slave_rdata  = v.sdata;
      q.push_back(v);
      address      = v.addr;
      write_data   = v.wdata;
      read_enable  = v.re;
      write_enable = v.we;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (stall && n < 50);
      if (stall) begin
         check("completion_timeout", {31'd0, stall}, 32'd0);
      end
   endtask

   task automatic go_idle(input int cycles);
      @(posedge clock);
      #1;
      read_enable  = 1'b0;
      write_enable = 1'b0;
      repeat (cycles) @(posedge clock);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      //          addr          wdata         re  we  mode wt sdata         stall bus err rd
      vecs[0] = '{32'h0000_0100, 32'h0000_0000, 1'b1, 1'b0, 0, 0, 32'hDEAD_BEEF, 2, 1, 1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{32'h0000_0200, 32'h1234_5678, 1'b0, 1'b1, 0, 3, 32'h5555_5555, 5, 4, 1'b0, 32'hDEAD_BEEF};
      vecs[2] = '{32'h0000_0104, 32'h0000_0000, 1'b1, 1'b0, 1, 0, 32'hBAD0_BAD0, 2, 1, 1'b1, 32'hDEAD_BEEF};
      vecs[3] = '{32'h0000_0108, 32'h0000_0000, 1'b1, 1'b0, 2, 0, 32'h7777_7777, 5, 4, 1'b1, 32'hDEAD_BEEF};
      vecs[4] = '{32'h0000_0102, 32'h0000_0000, 1'b1, 1'b0, 0, 0, 32'h9999_9999, 1, 0, 1'b1, 32'hDEAD_BEEF};
      vecs[5] = '{32'h0000_010C, 32'h0000_0000, 1'b1, 1'b0, 0, 2, 32'hCAFE_F00D, 4, 3, 1'b0, 32'hCAFE_F00D};
      vecs[6] = '{32'h0000_0300, 32'hA5A5_A5A5, 1'b1, 1'b1, 0, 1, 32'h3333_3333, 3, 2, 1'b0, 32'hCAFE_F00D};
      vecs[7] = '{32'h0000_0201, 32'h0BAD_0BAD, 1'b0, 1'b1, 0, 0, 32'h4444_4444, 1, 0, 1'b1, 32'hCAFE_F00D};
      vecs[8] = '{32'h0000_0400, 32'h0000_0000, 1'b1, 1'b0, 0, 0, 32'h1111_1111, 2, 1, 1'b0, 32'h1111_1111};
      vecs[9] = '{32'h0000_0404, 32'h0000_0000, 1'b1, 1'b0, 0, 0, 32'h2222_2222, 2, 1, 1'b0, 32'h2222_2222};

      reset        = 1'b1;
      address      = '0;
      read_enable  = 1'b0;
      write_enable = 1'b0;
      write_data   = '0;
      slave_mode   = 0;
      slave_wait   = 0;
      slave_rdata  = '0;

      #2;
      check("reset_read_data", read_data, 32'd0);
      check("reset_ctrl", {25'd0, stall, bus_error, wb_cyc_o, wb_stb_o, wb_we_o, 2'b00}, 32'd0);
      check("reset_adr",  wb_adr_o, 32'd0);
      check("reset_dat",  wb_dat_o, 32'd0);
      check("reset_sel",  {28'd0, wb_sel_o}, 32'd0);

      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clock);

      run_vec(vecs[0]);
      run_vec(vecs[1]);
      go_idle(2);
      run_vec(vecs[2]);
      run_vec(vecs[3]);
      go_idle(1);
      run_vec(vecs[4]);
      run_vec(vecs[5]);
      run_vec(vecs[6]);
      go_idle(1);
      run_vec(vecs[7]);
      go_idle(2);

      // Reset in the second BUS cycle of a read that the slave never answers.
      @(posedge clock);
      #1;
      slave_mode   = 2;
      address      = 32'h0000_0500;
      write_data   = '0;
      read_enable  = 1'b1;
      write_enable = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      check("cyc_before_reset", {31'd0, wb_cyc_o}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check("reset_mid_cyc",   {31'd0, wb_cyc_o}, 32'd0);
      check("reset_mid_stb",   {31'd0, wb_stb_o}, 32'd0);
      check("reset_mid_stall", {31'd0, stall},    32'd0);
      check("reset_mid_rdata", read_data,         32'd0);
      read_enable = 1'b0;
      @(posedge clock);
      #1;
      reset      = 1'b0;
      slave_mode = 0;
      @(posedge clock);

      run_vec(vecs[8]);
      run_vec(vecs[9]);
      go_idle(3);

      check("scoreboard_drained", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
